// File: rtl/reg_ctx_sequencer.sv
// Register-context save/restore engine.
// Save walks GPRs FIRST_REG..LAST_REG through the read port and stores each one
// to base + ADDR_STRIDE*idx. Restore loads the same slots and writes them back
// through the register-file write port.
//
// Memory handshake: mem_req is raised together with stable mem_we, mem_addr and
// mem_wdata. All four hold until a rising edge samples mem_ack=1, and that edge
// completes the access. mem_ack is ignored while mem_req=0.
module reg_ctx_sequencer #(
  parameter int unsigned FIRST_REG   = 1,
  parameter int unsigned LAST_REG    = 31,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        save_req,
  input  logic        restore_req,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_sel,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SV_RD = 3'd1,
    SV_WR = 3'd2,
    RS_RD = 3'd3,
    RS_WR = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [4:0]  FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_IDX  = 5'(LAST_REG);
  localparam logic [31:0] STRIDE    = 32'(ADDR_STRIDE);

  state_t      state, state_d;
  logic [4:0]  idx, idx_d;
  logic [31:0] base, base_d;
  logic        busy_d, done_d, rf_we_d, mem_req_d, mem_we_d;
  logic [4:0]  rf_wsel_d;
  logic [31:0] rf_wdata_d, mem_addr_d, mem_wdata_d;

  // Slot address; 32-bit arithmetic wraps modulo 2^32 by construction.
  function automatic logic [31:0] slot_addr(input logic [31:0] b, input logic [4:0] i);
    return b + STRIDE * {27'd0, i};
  endfunction

  // The read select follows the index directly so rf_rdata is valid in SV_RD.
  assign rf_sel = idx;

  // State, index, captured base and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= FIRST_IDX;
      base      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_we     <= 1'b0;
      rf_wsel   <= '0;
      rf_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      base      <= base_d;
      busy      <= busy_d;
      done      <= done_d;
      rf_we     <= rf_we_d;
      rf_wsel   <= rf_wsel_d;
      rf_wdata  <= rf_wdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    base_d      = base;
    busy_d      = busy;
    done_d      = 1'b0;
    rf_we_d     = 1'b0;
    rf_wsel_d   = rf_wsel;
    rf_wdata_d  = rf_wdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (save_req) begin
          state_d = SV_RD;
          idx_d   = FIRST_IDX;
          base_d  = base_addr;
          busy_d  = 1'b1;
        end else if (restore_req) begin
          state_d    = RS_RD;
          idx_d      = FIRST_IDX;
          base_d     = base_addr;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = slot_addr(base_addr, FIRST_IDX);
        end
      end
      SV_RD: begin
        mem_wdata_d = rf_rdata;
        mem_addr_d  = slot_addr(base, idx);
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        state_d     = SV_WR;
      end
      SV_WR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (idx == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx + 5'd1;
            state_d = SV_RD;
          end
        end
      end
      RS_RD: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          rf_wdata_d = mem_rdata;
          rf_wsel_d  = idx;
          // r0 is hardwired; never pulse a write at it.
          rf_we_d    = (idx != 5'd0);
          state_d    = RS_WR;
        end
      end
      RS_WR: begin
        if (idx == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx + 5'd1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = slot_addr(base, idx + 5'd1);
          state_d    = RS_RD;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Bench for reg_ctx_sequencer: register-file and memory models, a randomized
// ack responder, and one task per scenario.
module tb_reg_ctx_sequencer;

  localparam int unsigned FIRST = 1;
  localparam int unsigned LAST = 31;
  localparam int unsigned STRIDE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        save_req, restore_req, busy, done, rf_we, mem_req, mem_we, mem_ack;
  logic [31:0] base_addr, rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  rf_sel, rf_wsel;

  logic        w_save_req, w_restore_req, w_busy, w_done, w_rf_we, w_mem_req, w_mem_we, w_mem_ack;
  logic [31:0] w_base_addr, w_rf_rdata, w_rf_wdata, w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic [4:0]  w_rf_sel, w_rf_wsel;

  int checks = 0;
  int errors = 0;

  // models
  logic [31:0] rf[32];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] st_addr_q[$];
  logic [31:0] st_data_q[$];
  int ack_wait_max = 0;
  bit ack_hold = 1'b0;
  int wait_cnt = 0;
  int cur_wait = 0;
  int rf_we_cnt = 0;
  int overlap_cnt = 0;

  assign rf_rdata = rf[rf_sel];
  assign w_rf_rdata = rf[w_rf_sel];

  reg_ctx_sequencer #(.FIRST_REG(FIRST), .LAST_REG(LAST), .ADDR_STRIDE(STRIDE)) u_dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .rf_sel(rf_sel),
    .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  reg_ctx_sequencer #(.FIRST_REG(31), .LAST_REG(31), .ADDR_STRIDE(4)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .save_req(w_save_req), .restore_req(w_restore_req),
    .base_addr(w_base_addr), .busy(w_busy), .done(w_done), .rf_sel(w_rf_sel),
    .rf_rdata(w_rf_rdata), .rf_we(w_rf_we), .rf_wsel(w_rf_wsel), .rf_wdata(w_rf_wdata),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata)
  );

  // register-file write port model (r0 hardwired to its value)
  initial begin
    forever begin
      @(posedge clk);
      if (rf_we && rf_wsel != 5'd0) rf[rf_wsel] <= rf_wdata;
    end
  end

  // memory responder: acks after a random number of waits, logs stores
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && !ack_hold && rst_n) begin
        if (wait_cnt >= cur_wait) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          cur_wait = int'($urandom_range(ack_wait_max, 0));
          if (mem_we) begin
            st_addr_q.push_back(mem_addr);
            st_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // protocol monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we) rf_we_cnt++;
      if (rf_we && mem_req) overlap_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic start_xfer(input bit do_save, input logic [31:0] b);
    @(negedge clk);
    save_req = do_save;
    restore_req = !do_save;
    base_addr = b;
    @(negedge clk);
    save_req = 1'b0;
    restore_req = 1'b0;
    base_addr = $urandom;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    ok = done;
  endtask

  task automatic prep_idle(input int wmax);
    ack_wait_max = wmax;
    cur_wait = 0;
    wait_cnt = 0;
    st_addr_q.delete();
    st_data_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, rf_we, mem_req, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, rf_we, mem_req, mem_we});
    end
    checks++;
    if ({rf_wsel, rf_wdata} !== 37'h0) begin
      errors++;
      $display("FAIL reset_rf_out: got %h/%h expected 0/0", rf_wsel, rf_wdata);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem_out: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({w_busy, w_done, w_rf_we, w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata} !== 69'h0) begin
      errors++;
      $display("FAIL reset_wrap_dut: outputs not zero in reset");
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_req, rf_we} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {busy, mem_req, rf_we});
    end
  endtask

  task automatic test_save_full();
    logic [31:0] exp_q[$];
    logic [31:0] exp_a_q[$];
    int cycles;
    bit ok;
    prep_idle(0);
    rf[0] = 32'h0;
    for (int k = 1; k < 32; k++) rf[k] = 32'(k) * 32'h11;
    for (int k = FIRST; k <= LAST; k++) begin
      exp_a_q.push_back(32'h1000 + 32'(STRIDE * k));
      exp_q.push_back(32'(k) * 32'h11);
    end
    start_xfer(1'b1, 32'h1000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL save_busy_start: got %b expected 1", busy);
    end
    wait_done(200, cycles, ok);
    checks++;
    if (!ok || cycles !== 63) begin
      errors++;
      $display("FAIL save_done_cycle: got %0d (done=%b) expected 63", cycles, ok);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL save_after_done: got %b expected 00", {busy, done});
    end
    checks++;
    if (st_addr_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL save_count: got %0d expected %0d", st_addr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < st_addr_q.size(); i++) begin
      checks++;
      if (st_addr_q[i] !== exp_a_q[i] || st_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL save_store[%0d]: got %h@%h expected %h@%h", i, st_data_q[i], st_addr_q[i], exp_q[i], exp_a_q[i]);
      end
    end
  endtask

  task automatic test_restore_random_wait();
    int cycles;
    bit ok;
    prep_idle(3);
    mem.delete();
    for (int i = 0; i < 32; i++) mem[32'h2000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    rf[0] = 32'h0;
    for (int k = 1; k < 32; k++) rf[k] = 32'hDEAD_0000 | 32'(k);
    rf_we_cnt = 0;
    start_xfer(1'b0, 32'h2000);
    wait_done(1000, cycles, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restore_done: got no done within %0d cycles expected done", cycles);
    end
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (rf[k] !== ((k == 0) ? 32'h0 : 32'hA0 + 32'(k))) begin
        errors++;
        $display("FAIL restore_r%0d: got %h expected %h", k, rf[k], (k == 0) ? 32'h0 : 32'hA0 + 32'(k));
      end
    end
    checks++;
    if (rf_we_cnt !== 31) begin
      errors++;
      $display("FAIL restore_we_pulses: got %0d expected 31", rf_we_cnt);
    end
    checks++;
    if (st_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL restore_no_store: got %0d stores expected 0", st_addr_q.size());
    end
  endtask

  task automatic test_both_req();
    int cycles;
    bit ok;
    bit seen;
    bit extra;
    prep_idle(0);
    @(negedge clk);
    save_req = 1'b1;
    restore_req = 1'b1;
    base_addr = $urandom;
    @(negedge clk);
    save_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (mem_req) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL both_req_save_wins: got req=%b we=%b expected req=1 we=1", seen, mem_we);
    end
    wait_done(300, cycles, ok);
    restore_req = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL both_req_done: got no done expected done");
    end
    extra = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy || mem_req) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_ignored: got second transfer=%b expected 0", extra);
    end
    checks++;
    if (st_addr_q.size() !== 31) begin
      errors++;
      $display("FAIL both_req_store_count: got %0d expected 31", st_addr_q.size());
    end
  endtask

  task automatic test_stall();
    logic [31:0] b;
    logic [31:0] img1;
    int cycles;
    bit ok;
    bit seen;
    prep_idle(0);
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    img1 = rf[FIRST];
    b = $urandom;
    ack_hold = 1'b1;
    start_xfer(1'b1, b);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (mem_req) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_req_seen: got no mem_req expected mem_req");
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== b + 32'(STRIDE * FIRST) || mem_wdata !== img1 || rf_sel !== 5'(FIRST)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b addr=%h data=%h sel=%0d expected 1 %h %h %0d",
                 c, mem_req, mem_addr, mem_wdata, rf_sel, b + 32'(STRIDE * FIRST), img1, FIRST);
      end
      @(negedge clk);
    end
    ack_hold = 1'b0;
    wait_done(300, cycles, ok);
    checks++;
    if (!ok || st_addr_q.size() !== 31) begin
      errors++;
      $display("FAIL stall_complete: got done=%b stores=%0d expected 1 31", ok, st_addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] img[32];
    bit found;
    bit quiet;
    prep_idle(2);
    mem.delete();
    for (int k = 0; k < 32; k++) begin
      img[k] = $urandom;
      mem[32'h3000 + 32'(4 * k)] = img[k];
      rf[k] = (k == 0) ? 32'h0 : 32'h5500_0000 + 32'(k);
    end
    start_xfer(1'b0, 32'h3000);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (rf_we && rf_wsel == 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach_r7: got no r7 write cycle expected one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rf_we, mem_req, mem_we, rf_wsel, rf_wdata, mem_addr, mem_wdata} !== 106'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got busy=%b we=%b req=%b addr=%h expected all 0", busy, rf_we, mem_req, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || busy || rf_we) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_quiet: got activity after reset expected none");
    end
    for (int k = 1; k < 32; k++) begin
      checks++;
      if (rf[k] !== ((k < 7) ? img[k] : 32'h5500_0000 + 32'(k))) begin
        errors++;
        $display("FAIL rst_mid_r%0d: got %h expected %h", k, rf[k], (k < 7) ? img[k] : 32'h5500_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_random_rounds();
    logic [31:0] img[32];
    logic [31:0] b;
    logic [31:0] r0_val;
    int cycles;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      prep_idle(int'($urandom_range(3, 0)));
      b = $urandom;
      for (int k = 0; k < 32; k++) img[k] = (k == 0) ? 32'h0 : $urandom;
      for (int k = 0; k < 32; k++) rf[k] = img[k];
      start_xfer(1'b1, b);
      wait_done(1000, cycles, ok);
      checks++;
      if (!ok || st_addr_q.size() !== 31) begin
        errors++;
        $display("FAIL rnd%0d_save: got done=%b stores=%0d expected 1 31", r, ok, st_addr_q.size());
      end
      for (int i = 0; i < st_addr_q.size() && i < 31; i++) begin
        checks++;
        if (st_addr_q[i] !== b + 32'(STRIDE * (FIRST + i)) || st_data_q[i] !== img[FIRST + i]) begin
          errors++;
          $display("FAIL rnd%0d_store[%0d]: got %h@%h expected %h@%h", r, i, st_data_q[i], st_addr_q[i],
                   img[FIRST + i], b + 32'(STRIDE * (FIRST + i)));
        end
      end
      mem.delete();
      for (int k = 0; k < 32; k++) mem[b + 32'(STRIDE * k)] = img[k];
      r0_val = $urandom;
      rf[0] = r0_val;
      for (int k = 1; k < 32; k++) rf[k] = ~img[k];
      prep_idle(int'($urandom_range(3, 0)));
      start_xfer(1'b0, b);
      wait_done(1000, cycles, ok);
      @(negedge clk);
      checks++;
      if (!ok || rf[0] !== r0_val) begin
        errors++;
        $display("FAIL rnd%0d_restore_r0: got done=%b r0=%h expected 1 %h", r, ok, rf[0], r0_val);
      end
      for (int k = 1; k < 32; k++) begin
        checks++;
        if (rf[k] !== img[k]) begin
          errors++;
          $display("FAIL rnd%0d_restore_r%0d: got %h expected %h", r, k, rf[k], img[k]);
        end
      end
    end
  endtask

  task automatic test_wrap_single();
    logic [31:0] v;
    int cycles;
    int req_cycles;
    v = $urandom;
    rf[31] = v;
    w_mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    w_save_req = 1'b1;
    w_base_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    w_save_req = 1'b0;
    w_base_addr = $urandom;
    cycles = 1;
    req_cycles = 0;
    forever begin
      if (w_mem_req) begin
        req_cycles++;
        checks++;
        if (w_mem_addr !== 32'h0000_006C || w_mem_wdata !== v || w_mem_we !== 1'b1) begin
          errors++;
          $display("FAIL wrap_store: got %h@%h we=%b expected %h@0000006c we=1", w_mem_wdata, w_mem_addr, w_mem_we, v);
        end
      end
      if (w_done || cycles >= 20) break;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!w_done || cycles !== 3 || req_cycles !== 1) begin
      errors++;
      $display("FAIL wrap_timing: got done=%b cycle=%0d reqs=%0d expected 1 3 1", w_done, cycles, req_cycles);
    end
    @(negedge clk);
    w_mem_ack = 1'b0;
    checks++;
    if (w_busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got busy=%b expected 0", w_busy);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL we_req_overlap: got %0d cycles expected 0", overlap_cnt);
    end
  endtask

  initial begin
    save_req = 1'b0;
    restore_req = 1'b0;
    base_addr = '0;
    w_save_req = 1'b0;
    w_restore_req = 1'b0;
    w_base_addr = '0;
    w_mem_ack = 1'b0;
    w_mem_rdata = '0;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_save_full();
    test_restore_random_wait();
    test_both_req();
    test_stall();
    test_reset_mid();
    test_random_rounds();
    test_wrap_single();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
